// File: rtl/gpio_p2s.sv
// GPIO-style LED register with a serial shifter: writes land in {aux, LED, counter_set},
// and each shift sends the inverted LED snapshot out on ledclk/ledsout followed by a latch strobe.
module gpio_p2s #(
    parameter int          LED_BITS     = 16,
    parameter int          CSET_BITS    = 2,
    parameter int          CLK_DIV      = 2,
    parameter logic [31:0] LED_INIT     = 32'h0000_002A,
    parameter int          MSB_FIRST    = 0,
    parameter int          AUTO_REFRESH = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 EN,
    input  logic [31:0]          P_Data,
    input  logic                 Start,
    output logic [CSET_BITS-1:0] counter_set,
    output logic [LED_BITS-1:0]  LED_out,
    output logic [31:0]          GPIOf0,
    output logic                 ledclk,
    output logic                 ledsout,
    output logic                 ledclrn,
    output logic                 LEDEN,
    output logic                 busy
);

    localparam int AUX_BITS = 32 - LED_BITS - CSET_BITS;
    localparam int BW       = $clog2(LED_BITS + 1);
    localparam int DW       = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LED_BITS-1:0]   led_q, led_d;
    logic [CSET_BITS-1:0]  cset_q, cset_d;
    logic [LED_BITS-1:0]   sr_q, sr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DW-1:0]         div_q, div_d;
    logic                  phase_q, phase_d;
    logic                  pending_q, pending_d;
    logic                  ledclk_q, ledclk_d;
    logic                  ledsout_q, ledsout_d;
    logic                  ledclrn_q, ledclrn_d;
    logic                  leden_q, leden_d;
    logic                  busy_q, busy_d;
    logic [LED_BITS-1:0]   wr_led_s;
    logic                  auto_s;
    logic                  trig_s;

    assign wr_led_s = P_Data[CSET_BITS +: LED_BITS];
    assign auto_s   = (AUTO_REFRESH != 0) && EN && (wr_led_s != led_q);
    assign trig_s   = Start || auto_s;

    // Register-file write path
    always_comb begin
        led_d  = led_q;
        cset_d = cset_q;
        if (EN) begin
            led_d  = wr_led_s;
            cset_d = P_Data[CSET_BITS-1:0];
        end else begin
            led_d  = led_q;
            cset_d = cset_q;
        end
    end

    // Shift sequencer next state: LOAD snapshots the LED, SHIFT walks bits in low/high ledclk phases
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        div_d     = div_q;
        phase_d   = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_s || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                sr_d    = ~led_q;
                bit_d   = {BW{1'b0}};
                div_d   = {DW{1'b0}};
                phase_d = 1'b0;
                if (trig_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            ST_SHIFT: begin
                if (trig_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = {DW{1'b0}};
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == BW'(LED_BITS - 1)) begin
                        phase_d = 1'b0;
                        state_d = ST_LATCH;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + BW'(1);
                        sr_d    = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_LATCH: begin
                // A trigger landing in LATCH itself is kept for the following round
                state_d   = pending_q ? ST_LOAD : ST_IDLE;
                pending_d = trig_s;
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Output next values, decoded from the next state so the pins are flop outputs
    always_comb begin
        ledclk_d  = 1'b1;
        ledsout_d = 1'b1;
        if (state_d == ST_SHIFT) begin
            ledclk_d  = phase_d;
            ledsout_d = (MSB_FIRST != 0) ? sr_d[LED_BITS-1] : sr_d[0];
        end else begin
            ledclk_d  = 1'b1;
            ledsout_d = 1'b1;
        end
        ledclrn_d = (state_d != ST_LOAD);
        leden_d   = (state_d == ST_LATCH);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            led_q     <= LED_INIT[LED_BITS-1:0];
            cset_q    <= {CSET_BITS{1'b0}};
            sr_q      <= {LED_BITS{1'b0}};
            bit_q     <= {BW{1'b0}};
            div_q     <= {DW{1'b0}};
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
            ledclk_q  <= 1'b1;
            ledsout_q <= 1'b1;
            ledclrn_q <= 1'b1;
            leden_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            cset_q    <= cset_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            ledclk_q  <= ledclk_d;
            ledsout_q <= ledsout_d;
            ledclrn_q <= ledclrn_d;
            leden_q   <= leden_d;
            busy_q    <= busy_d;
        end
    end

    generate
        if (AUX_BITS > 0) begin : g_aux
            logic [AUX_BITS-1:0] aux_q, aux_d;

            // Upper spare bits of the write word
            always_comb begin
                aux_d = aux_q;
                if (EN) begin
                    aux_d = P_Data[31 -: AUX_BITS];
                end else begin
                    aux_d = aux_q;
                end
            end

            // Spare-bit register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    aux_q <= {AUX_BITS{1'b0}};
                end else begin
                    aux_q <= aux_d;
                end
            end

            assign GPIOf0 = {aux_q, led_q, cset_q};
        end else begin : g_noaux
            assign GPIOf0 = {led_q, cset_q};
        end
    endgenerate

    assign counter_set = cset_q;
    assign LED_out     = led_q;
    assign ledclk      = ledclk_q;
    assign ledsout     = ledsout_q;
    assign ledclrn     = ledclrn_q;
    assign LEDEN       = leden_q;
    assign busy        = busy_q;

endmodule
